// File: rtl/guess_entry.sv
// Keypad digit-entry front end: synchronises key strobes, edits a three-digit
// buffer and hands each completed guess to the game controller.
module guess_entry #(
  parameter bit ALLOW_DUP = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key_code,
  input  logic       key_strobe,
  output logic [3:0] oNum1,
  output logic [3:0] oNum2,
  output logic [3:0] oNum3,
  output logic       oNumRdy,
  output logic [1:0] digit_cnt,
  output logic       err,
  output logic [3:0] commit_cnt
);

  typedef enum logic [2:0] {EMPTY, ONE, TWO, FULL, COMMIT} state_e;

  state_e     state_q, state_d;
  logic       s1_q, s2_q, hist_q;
  logic [3:0] b1_q, b2_q, b3_q, b1_d, b2_d, b3_d;
  logic [3:0] o1_q, o2_q, o3_q, o1_d, o2_d, o3_d;
  logic [3:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic       key_evt, is_digit, dup;

  // Synchroniser resets low, so a strobe held through reset still yields one edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      hist_q <= 1'b0;
    end else begin
      s1_q   <= key_strobe;
      s2_q   <= s1_q;
      hist_q <= s2_q;
    end
  end

  assign key_evt  = s2_q & ~hist_q;
  assign is_digit = (key_code <= 4'd9);
  assign dup = !ALLOW_DUP &&
               (((state_q != EMPTY) && (key_code == b1_q)) ||
                (((state_q == TWO) || (state_q == FULL)) && (key_code == b2_q)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      b1_q    <= '0;
      b2_q    <= '0;
      b3_q    <= '0;
      o1_q    <= '0;
      o2_q    <= '0;
      o3_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      b1_q    <= b1_d;
      b2_q    <= b2_d;
      b3_q    <= b3_d;
      o1_q    <= o1_d;
      o2_q    <= o2_d;
      o3_q    <= o3_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    b1_d    = b1_q;
    b2_d    = b2_q;
    b3_d    = b3_q;
    o1_d    = o1_q;
    o2_d    = o2_q;
    o3_d    = o3_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    if (state_q == COMMIT) begin
      state_d = EMPTY;
      b1_d    = '0;
      b2_d    = '0;
      b3_d    = '0;
      if (cnt_q != 4'd15) cnt_d = cnt_q + 4'd1;
      err_d   = key_evt;  // an event landing on COMMIT is dropped
    end else if (key_evt) begin
      if (is_digit) begin
        if (state_q == FULL || dup) err_d = 1'b1;
        else begin
          case (state_q)
            EMPTY:   begin b1_d = key_code; state_d = ONE; end
            ONE:     begin b2_d = key_code; state_d = TWO; end
            default: begin b3_d = key_code; state_d = FULL; end
          endcase
        end
      end else begin
        case (key_code)
          4'hA: begin
            case (state_q)
              ONE:     begin b1_d = '0; state_d = EMPTY; end
              TWO:     begin b2_d = '0; state_d = ONE; end
              FULL:    begin b3_d = '0; state_d = TWO; end
              default: err_d = 1'b1;
            endcase
          end
          4'hB: begin
            if (state_q == FULL) begin
              state_d = COMMIT;
              o1_d    = b1_q;
              o2_d    = b2_q;
              o3_d    = b3_q;
            end else err_d = 1'b1;
          end
          4'hC: begin
            state_d = EMPTY;
            b1_d    = '0;
            b2_d    = '0;
            b3_d    = '0;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    digit_cnt = 2'd0;
    oNumRdy   = 1'b0;
    case (state_q)
      ONE:     digit_cnt = 2'd1;
      TWO:     digit_cnt = 2'd2;
      FULL:    digit_cnt = 2'd3;
      COMMIT:  oNumRdy   = 1'b1;
      default: ;
    endcase
  end

  assign oNum1      = o1_q;
  assign oNum2      = o2_q;
  assign oNum3      = o3_q;
  assign err        = err_q;
  assign commit_cnt = cnt_q;

endmodule
